// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, branch funct3 codes,
// flag bit positions and the stored result entry.
package ex_pkg;

  localparam int EX_XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Flags are packed as {v,c,n,z}.
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef struct packed {
    logic [EX_XLEN-1:0] result;
    logic [3:0]         flags;
  } ex_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_TWO
  } occ_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: result plus {v,c,n,z}; carry and overflow are only
// meaningful for add/sub and read 0 for every other op.
module alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      op_i,
  output logic [XLEN-1:0] result_o,
  output logic [3:0]      flags_o
);

  localparam int SHW = $clog2(XLEN);

  logic            is_sub;
  logic            is_arith;
  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum;
  logic [SHW-1:0]  shamt;

  // NOTE: every signal written here gets a value before the case so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    is_sub   = (op_i == ALU_SUB);
    is_arith = 1'b0;
    b_eff    = is_sub ? ~b_i : b_i;
    // Subtract as a + ~b + 1, so carry-out means "no borrow" (a >= b unsigned).
    sum      = {1'b0, a_i} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};
    shamt    = b_i[SHW-1:0];
    result_o = '0;
    case (op_i)
      ALU_ADD, ALU_SUB: begin
        result_o = sum[XLEN-1:0];
        is_arith = 1'b1;
      end
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      default:  result_o = '0;
    endcase
    flags_o[FLAG_Z] = (result_o == '0);
    flags_o[FLAG_N] = result_o[XLEN-1];
    flags_o[FLAG_C] = is_arith & sum[XLEN];
    flags_o[FLAG_V] = is_arith & (a_i[XLEN-1] == b_eff[XLEN-1])
                               & (sum[XLEN-1] != a_i[XLEN-1]);
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolution and a two-entry output/skid buffer
// with a registered id_ready; taken control flow raises a one-cycle redirect.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32  // entry storage is ex_entry_t, so XLEN must equal EX_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_a,
  input  logic [XLEN-1:0] id_b,
  input  logic [3:0]      id_alucontrol,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_branch,
  input  logic            id_jal,
  input  logic            id_jalr,
  input  logic [2:0]      id_funct3,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_result,
  output logic [3:0]      ex_flags,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_target
);

  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_result;
  logic [3:0]      alu_flags;

  assign alu_op = id_branch ? ALU_SUB : id_alucontrol;

  alu #(.XLEN(XLEN)) u_alu (
    .a_i      (id_a),
    .b_i      (id_b),
    .op_i     (alu_op),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  logic            is_link;
  logic            br_cond;
  logic            taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  ex_entry_t       new_entry;

  always_comb begin
    is_link = id_jal | id_jalr;
    case (id_funct3)
      F3_BEQ:  br_cond = alu_flags[FLAG_Z];
      F3_BNE:  br_cond = ~alu_flags[FLAG_Z];
      F3_BLT:  br_cond = alu_flags[FLAG_N] ^ alu_flags[FLAG_V];
      F3_BGE:  br_cond = ~(alu_flags[FLAG_N] ^ alu_flags[FLAG_V]);
      F3_BLTU: br_cond = ~alu_flags[FLAG_C];
      F3_BGEU: br_cond = alu_flags[FLAG_C];
      default: br_cond = 1'b0;
    endcase
    taken            = is_link | (id_branch & br_cond);
    jalr_sum         = id_a + id_imm;
    target           = id_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : id_pc + id_imm;
    new_entry.result = is_link ? id_pc + XLEN'(4) : alu_result;
    new_entry.flags  = alu_flags;
  end

  occ_e            state_q, state_d;
  ex_entry_t       out_q, out_d;
  ex_entry_t       skid_q, skid_d;
  logic            id_ready_q;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_target_q, redirect_target_d;
  logic            fire_in;
  logic            drain;

  assign fire_in = id_valid & id_ready_q;
  assign drain   = ex_valid & ex_ready;

  always_comb begin
    state_d           = state_q;
    out_d             = out_q;
    skid_d            = skid_q;
    redirect_valid_d  = 1'b0;
    redirect_target_d = redirect_target_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      if (fire_in && taken) begin
        redirect_valid_d  = 1'b1;
        redirect_target_d = target;
      end
      case (state_q)
        OCC_EMPTY: begin
          if (fire_in) begin
            out_d   = new_entry;
            state_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({fire_in, drain})
            2'b11: out_d = new_entry;
            2'b10: begin
              skid_d  = new_entry;
              state_d = OCC_TWO;
            end
            2'b01: state_d = OCC_EMPTY;
            default: ;
          endcase
        end
        OCC_TWO: begin
          // id_ready is low here, so only a drain can happen; skid moves up.
          if (drain) begin
            out_d   = skid_q;
            state_d = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the data registers are reset too, because ex_result and ex_flags
  // must read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= OCC_EMPTY;
      out_q             <= '0;
      skid_q            <= '0;
      id_ready_q        <= 1'b1;
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
    end else begin
      state_q           <= state_d;
      out_q             <= out_d;
      skid_q            <= skid_d;
      id_ready_q        <= (state_d != OCC_TWO);
      redirect_valid_q  <= redirect_valid_d;
      redirect_target_q <= redirect_target_d;
    end
  end

  assign id_ready        = id_ready_q;
  assign ex_valid        = (state_q != OCC_EMPTY);
  assign ex_result       = out_q.result;
  assign ex_flags        = out_q.flags;
  assign redirect_valid  = redirect_valid_q;
  assign redirect_target = redirect_target_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int XLEN = 32;
  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;

  logic            clk = 1'b0;
  logic            reset, flush, id_valid, id_ready;
  logic [XLEN-1:0] id_a, id_b, id_pc, id_imm;
  logic [3:0]      id_alucontrol;
  logic            id_branch, id_jal, id_jalr;
  logic [2:0]      id_funct3;
  logic            ex_valid, ex_ready;
  logic [XLEN-1:0] ex_result;
  logic [3:0]      ex_flags;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(XLEN)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_a            (id_a),
    .id_b            (id_b),
    .id_alucontrol   (id_alucontrol),
    .id_pc           (id_pc),
    .id_imm          (id_imm),
    .id_branch       (id_branch),
    .id_jal          (id_jal),
    .id_jalr         (id_jalr),
    .id_funct3       (id_funct3),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_result       (ex_result),
    .ex_flags        (ex_flags),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  typedef struct {
    logic [31:0] result;
    logic [3:0]  flags;
    bit          taken;
    logic [31:0] target;
  } ref_t;

  int   n_vec = 0;
  int   n_err = 0;
  ref_t q[$];
  bit   exp_rv;
  logic [31:0] exp_tgt;
  bit   rst_clean;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected behaviour of one instruction, from plain integer arithmetic.
  function automatic ref_t ref_model();
    ref_t        e;
    logic [31:0] a, b, r;
    logic [3:0]  op;
    longint      sa, sb, wide;
    longint unsigned ua, ub;
    bit          v, c;
    a  = id_a;
    b  = id_b;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    op = id_branch ? ALU_SUB : id_alucontrol;
    v  = 0;
    c  = 0;
    r  = '0;
    case (op)
      ALU_ADD: begin
        r = a + b; wide = sa + sb;
        v = (wide > S_MAX) || (wide < S_MIN);
        c = ((ua + ub) >> 32) != 0;
      end
      ALU_SUB: begin
        r = a - b; wide = sa - sb;
        v = (wide > S_MAX) || (wide < S_MIN);
        c = (a >= b);
      end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      default:  r = '0;
    endcase
    e.flags = {v, c, r[31], r == 32'd0};
    e.result = (id_jal || id_jalr) ? id_pc + 32'd4 : r;
    if (id_jal || id_jalr) e.taken = 1;
    else if (id_branch) begin
      case (id_funct3)
        3'b000:  e.taken = (a == b);
        3'b001:  e.taken = (a != b);
        3'b100:  e.taken = (sa < sb);
        3'b101:  e.taken = (sa >= sb);
        3'b110:  e.taken = (a < b);
        3'b111:  e.taken = (a >= b);
        default: e.taken = 0;
      endcase
    end else e.taken = 0;
    e.target = id_jalr ? ((a + id_imm) & ~32'h1) : id_pc + id_imm;
    return e;
  endfunction

  // Check outputs mid-cycle, advance the model by the coming edge, then
  // return just after that edge.
  task automatic cycle();
    ref_t e;
    bit   fire, drain;
    @(negedge clk);
    check("ex_valid", ex_valid, q.size() > 0);
    check("id_ready", id_ready, q.size() < 2);
    check("redirect_valid", redirect_valid, exp_rv);
    check("redirect_target", redirect_target, exp_tgt);
    if (q.size() > 0) begin
      check("ex_result", ex_result, q[0].result);
      check("ex_flags", ex_flags, q[0].flags);
    end else if (rst_clean) begin
      check("ex_result_rst", ex_result, 0);
      check("ex_flags_rst", ex_flags, 0);
    end
    e     = ref_model();
    fire  = id_valid && (q.size() < 2);
    drain = (q.size() > 0) && ex_ready;
    if (reset) begin
      q.delete();
      exp_rv    = 0;
      exp_tgt   = '0;
      rst_clean = 1;
    end else if (flush) begin
      q.delete();
      exp_rv = 0;
    end else begin
      if (drain) void'(q.pop_front());
      if (fire) begin
        q.push_back(e);
        rst_clean = 0;
      end
      exp_rv = fire && e.taken;
      if (exp_rv) exp_tgt = e.target;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] pc, input logic [31:0] imm,
                       input bit br, input bit jal, input bit jalr, input logic [2:0] f3);
    id_valid      = v;
    id_a          = a;
    id_b          = b;
    id_alucontrol = op;
    id_pc         = pc;
    id_imm        = imm;
    id_branch     = br;
    id_jal        = jal;
    id_jalr       = jalr;
    id_funct3     = f3;
  endtask

  task automatic idle();
    drive(0, '0, '0, ALU_ADD, '0, '0, 0, 0, 0, 3'b000);
  endtask

  logic [3:0] ops [10] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                           ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA};

  task automatic random_inst();
    int unsigned kind;
    logic [31:0] a, b;
    kind = $urandom_range(0, 5);
    a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    case ($urandom_range(0, 3))
      0:       b = a;
      1:       b = 32'($urandom_range(0, 40));
      default: b = $urandom;
    endcase
    drive($urandom_range(0, 9) < 7, a, b, ops[$urandom_range(0, 9)], $urandom, $urandom,
          kind == 3, kind == 4, kind == 5, 3'($urandom_range(0, 7)));
  endtask

  initial begin
    reset    = 1;
    flush    = 0;
    ex_ready = 0;
    idle();
    @(posedge clk);
    #1;
    q.delete();
    exp_rv    = 0;
    exp_tgt   = '0;
    rst_clean = 1;
    cycle();
    reset = 0;

    // Streaming adds with no backpressure.
    ex_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'd5, 32'd7, ALU_ADD, '0, '0, 0, 0, 0, 3'b000);
      cycle();
      check("stream_valid", ex_valid, 1);
      check("stream_result", ex_result, 12);
      check("stream_ready", id_ready, 1);
    end
    idle();
    cycle();

    // Backpressure: third op is held off until the skid drains.
    ex_ready = 0;
    drive(1, 32'd1, 32'd1, ALU_ADD, '0, '0, 0, 0, 0, 3'b000);
    cycle();
    drive(1, 32'd2, 32'd2, ALU_ADD, '0, '0, 0, 0, 0, 3'b000);
    cycle();
    check("bp_ready_low", id_ready, 0);
    drive(1, 32'd3, 32'd3, ALU_ADD, '0, '0, 0, 0, 0, 3'b000);
    cycle();
    check("bp_hold_result", ex_result, 2);
    check("bp_ready_still_low", id_ready, 0);
    ex_ready = 1;
    cycle();
    check("bp_second", ex_result, 4);
    cycle();
    check("bp_third", ex_result, 6);
    idle();
    cycle();
    check("bp_empty", ex_valid, 0);

    // blt taken, then bltu with the same operands not taken.
    drive(1, 32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'h100, 32'h20, 1, 0, 0, 3'b100);
    cycle();
    check("blt_redirect", redirect_valid, 1);
    check("blt_target", redirect_target, 32'h120);
    idle();
    cycle();
    check("blt_pulse_end", redirect_valid, 0);
    drive(1, 32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'h100, 32'h20, 1, 0, 0, 3'b110);
    cycle();
    check("bltu_no_redirect", redirect_valid, 0);
    idle();
    cycle();

    // jalr link value and aligned target.
    drive(1, 32'h203, 32'd0, ALU_ADD, 32'h40, 32'h4, 0, 0, 1, 3'b000);
    cycle();
    check("jalr_result", ex_result, 32'h44);
    check("jalr_redirect", redirect_valid, 1);
    check("jalr_target", redirect_target, 32'h206);
    idle();
    cycle();

    // Flush with two entries held and a jal presented.
    ex_ready = 0;
    drive(1, 32'd10, 32'd20, ALU_ADD, '0, '0, 0, 0, 0, 3'b000);
    cycle();
    cycle();
    check("two_full", id_ready, 0);
    flush = 1;
    drive(1, '0, '0, ALU_ADD, 32'h300, 32'h10, 0, 1, 0, 3'b000);
    cycle();
    flush = 0;
    check("flush_valid", ex_valid, 0);
    check("flush_ready", id_ready, 1);
    check("flush_redirect", redirect_valid, 0);
    // Flush in the same cycle as an accepted jal.
    drive(1, 32'd4, 32'd4, ALU_XOR, '0, '0, 0, 0, 0, 3'b000);
    cycle();
    flush = 1;
    drive(1, '0, '0, ALU_ADD, 32'h400, 32'h10, 0, 1, 0, 3'b000);
    cycle();
    flush = 0;
    check("flush_fire_valid", ex_valid, 0);
    check("flush_fire_redirect", redirect_valid, 0);
    idle();
    cycle();

    // Reset with two entries held and a redirect in flight.
    drive(1, 32'd1, 32'd2, ALU_ADD, '0, '0, 0, 0, 0, 3'b000);
    cycle();
    drive(1, '0, '0, ALU_ADD, 32'h500, 32'h40, 0, 1, 0, 3'b000);
    cycle();
    check("pre_reset_redirect", redirect_valid, 1);
    check("pre_reset_full", id_ready, 0);
    reset = 1;
    flush = 1;
    cycle();
    reset = 0;
    flush = 0;
    check("rst_valid", ex_valid, 0);
    check("rst_ready", id_ready, 1);
    check("rst_redirect", redirect_valid, 0);
    check("rst_result", ex_result, 0);
    check("rst_flags", ex_flags, 0);
    check("rst_target", redirect_target, 0);
    idle();
    cycle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      ex_ready = ($urandom_range(0, 9) < 6);
      random_inst();
      cycle();
    end
    reset    = 0;
    flush    = 0;
    ex_ready = 1;
    idle();
    for (int i = 0; i < 4; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; all other values fixed at 32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous squash of all held and incoming work.
REQ-005 SHALL have ports id_valid  input  1 and id_ready  output  1  upstream handshake.
REQ-006 SHALL have ports id_a and id_b, both input XLEN, ALU operands from decode.
REQ-007 SHALL have ports id_alucontrol  input  4 (ALU op), id_pc  input  XLEN, id_imm  input  XLEN.
REQ-008 SHALL have ports id_branch, id_jal and id_jalr, each input 1, plus id_funct3  input  3 (branch type).
REQ-009 SHALL have ports ex_valid  output  1 and ex_ready  input  1  downstream handshake.
REQ-010 SHALL have ports ex_result  output  XLEN and ex_flags  output  4 {v,c,n,z}.
REQ-011 SHALL have ports redirect_valid  output  1 and redirect_target  output  XLEN  fetch redirect.

Function
REQ-012 Upstream transfer (fire_in) SHALL occur when id_valid and id_ready are both 1; downstream transfer when ex_valid and ex_ready are both 1.
REQ-013 On fire_in the stage SHALL compute through the ALU combinationally and capture {result, flags} into the output register or, if that is occupied and not draining, into the skid register.
REQ-014 Latency SHALL be 1 cycle from fire_in to ex_valid with an empty stage; throughput SHALL be 1 instruction per cycle while ex_ready is held at 1.
REQ-015 id_ready SHALL be a registered signal equal to NOT skid_full; the skid entry SHALL absorb the one transfer accepted while ready falls.
REQ-016 Occupancy states SHALL be EMPTY, ONE (output register only) and TWO (output plus skid); the skid entry SHALL never be valid while the output register is empty.
REQ-017 Transitions: EMPTY→ONE on fire_in; ONE→TWO on fire_in without drain; ONE→EMPTY on drain without fire_in; TWO→ONE on drain, moving skid to output in the same cycle; simultaneous fire_in and drain SHALL hold the state.
REQ-018 Data order SHALL be strictly FIFO; no entry is dropped or duplicated except by flush or reset.
REQ-019 When id_branch=1, the ALU op SHALL be forced to 4'b0001 (subtract), and the stored result SHALL be the subtraction result.
REQ-020 Branch taken SHALL be beq 000: z; bne 001: !z; blt 100: n^v; bge 101: !(n^v); bltu 110: !c; bgeu 111: c; codes 010 and 011 SHALL be not taken.
REQ-021 When id_jal or id_jalr is 1, the stored result SHALL be id_pc+4, and the instruction SHALL always be taken.
REQ-022 Target SHALL be id_pc+id_imm for branch and jal, and (id_a+id_imm) with bit 0 cleared for jalr, in modulo-2^XLEN arithmetic.
REQ-023 redirect_valid SHALL pulse exactly 1 cycle, in the cycle after fire_in of a taken instruction, with redirect_target registered alongside it; this SHALL not depend on ex_ready.
REQ-024 flush SHALL, next cycle, set ex_valid=0, clear skid, set redirect_valid=0 and id_ready=1; any fire_in in the flush cycle SHALL be discarded.
REQ-025 Flags SHALL be driven only from the ALU for the captured instruction; v and c are 0 for non-add/sub ops.
REQ-026 ex_result and ex_flags SHALL hold stable while ex_valid=1 and ex_ready=0.

Reset
REQ-027 While reset=1 at a clock edge: ex_valid=0, skid empty, redirect_valid=0, id_ready=1, ex_result=0, ex_flags=0, redirect_target=0.
REQ-028 Reset mid-operation SHALL discard all held entries and any pending redirect, and SHALL take priority over flush and fire_in.

Structure
REQ-029 Shared package ex_pkg SHALL hold the ALU op localparams (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 1001, SLL 0110, SRL 0111, SRA 1000), branch funct3 codes, and the struct ex_entry_t {result, flags}.
REQ-030 The existing alu module SHALL be instantiated once as the sole sub-module; the branch compare, target adders and skid logic SHALL be in ex_stage.

Verification
REQ-031 Add streaming: a=5, b=7, op 0000, for 4 back-to-back cycles with ex_ready=1 -> ex_result=12 each cycle, 1-cycle latency, id_ready constant 1.
REQ-032 Backpressure: ex_ready=0 for 3 cycles while sending 3 ops -> id_ready falls after 2 accepted, both outputs emerge in order, nothing lost.
REQ-033 blt: a=-1, b=1, funct3 100, pc=0x100, imm=0x20 -> redirect_valid pulse with target 0x120; the same operands with bltu -> no redirect.
REQ-034 jalr: a=0x203, imm=0x4, pc=0x40 -> ex_result=0x44 and redirect_target=0x206.
REQ-035 Flush in state TWO with a simultaneous fire_in -> next cycle ex_valid=0, id_ready=1, and no redirect.
REQ-036 Reset asserted in state TWO with a pending redirect -> all outputs at reset values the next cycle.
